// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN window-scan blocks.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } scan_state_t;

  // Sum of four signed data_width x data_width products needs two guard bits.
  function automatic int acc_w(input int dw);
    return 2 * dw + 2;
  endfunction

  localparam int ACC_W = acc_w(8);

endpackage

// File: rtl/mac4.sv
// Combinational signed 4-way dot product: acc = sum(w[i] * d[i]).
module mac4
  import cnn_pkg::*;
#(
  parameter int DW = 8,
  parameter int RW = acc_w(DW)
) (
  input  logic [3:0][DW-1:0] w,
  input  logic [3:0][DW-1:0] d,
  output logic signed [RW-1:0] acc
);

  logic signed [2*DW-1:0] prod [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign prod[i] = $signed(w[i]) * $signed(d[i]);
  end

  assign acc = RW'(prod[0]) + RW'(prod[1]) + RW'(prod[2]) + RW'(prod[3]);

endmodule

// File: rtl/mac4_window_scan.sv
// Scans every 2x2 window of a row-major tile in the register file and streams
// the weighted window sums out over a valid/ready handshake.
module mac4_window_scan
  import cnn_pkg::*;
#(
  parameter int data_width = 8,
  parameter int tile_w     = 4,
  parameter int tile_h     = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic [data_width-1:0]          w0,
  input  logic [data_width-1:0]          w1,
  input  logic [data_width-1:0]          w2,
  input  logic [data_width-1:0]          w3,
  output logic [4:0]                     add_1,
  output logic [4:0]                     add_2,
  output logic [4:0]                     add_3,
  output logic [4:0]                     add_4,
  input  logic [data_width-1:0]          out1,
  input  logic [data_width-1:0]          out2,
  input  logic [data_width-1:0]          out3,
  input  logic [data_width-1:0]          out4,
  output logic signed [2*data_width+1:0] res,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int RW = acc_w(data_width);
  localparam int CB = (tile_w > 2) ? $clog2(tile_w) : 1;
  localparam int RB = (tile_h > 2) ? $clog2(tile_h) : 1;
  localparam logic [CB-1:0] C_LAST = CB'(tile_w - 2);
  localparam logic [RB-1:0] R_LAST = RB'(tile_h - 2);

  scan_state_t                  state_q, state_d;
  logic [RB-1:0]                r_q, r_d;
  logic [CB-1:0]                c_q, c_d;
  logic [3:0][data_width-1:0]   w_q, w_d;
  logic signed [RW-1:0]         res_q, res_d;
  logic                         vld_q, vld_d;
  logic                         done_q, done_d;
  logic signed [RW-1:0]         mac_res;
  logic [4:0]                   base;
  logic                         run;

  assign run  = (state_q == RUN);
  assign base = 5'(int'(r_q) * tile_w + int'(c_q));

  // Addresses are only meaningful while scanning; park them at 0 otherwise.
  assign add_1 = run ? base                   : 5'd0;
  assign add_2 = run ? base + 5'd1            : 5'd0;
  assign add_3 = run ? base + 5'(tile_w)      : 5'd0;
  assign add_4 = run ? base + 5'(tile_w + 1)  : 5'd0;

  mac4 #(.DW(data_width), .RW(RW)) u_mac4 (
    .w   (w_q),
    .d   ({out4, out3, out2, out1}),
    .acc (mac_res)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    w_d     = w_q;
    res_d   = res_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          w_d     = {w3, w2, w1, w0};
          r_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        // A new result may be loaded whenever the output slot is empty or draining.
        if (!vld_q || res_ready) begin
          res_d = mac_res;
          vld_d = 1'b1;
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              r_d     = '0;
              state_d = FLUSH;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (vld_q && res_ready) begin
          vld_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      w_q     <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      w_q     <= w_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign res       = res_q;
  assign res_valid = vld_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
